ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
// Iterative RV32M multiply/divide unit in the execute stage. It sits beside the ALU.
// It consumes the same ALU_srcA operand and the srcB-mux output ALU_srcB.
// It computes one result bit per cycle (32-cycle ops), or finishes early on divide special cases.
// The hazard unit stalls the pipeline on MD_BUSY and writes MD_RESULT back when MD_VALID pulses.
// PARAMETERS
// XLEN   32   operand/result width; the counter is $clog2(XLEN) bits; only 32 is verified
// PORTS
// CLK        in   1     rising-edge clock
// RST_N      in   1     async active-low reset
// MD_START   in   1     one-cycle request; operands and MD_FUN sampled this cycle
// MD_FUN     in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
// ALU_srcA   in   XLEN  rs1 operand (dividend / multiplicand)
// ALU_srcB   in   XLEN  rs2 operand from srcB mux (divisor / multiplier)
// FLUSH      in   1     synchronous abort of any in-flight op
// MD_BUSY    out  1     high while state==CALC
// MD_VALID   out  1     one-cycle pulse; MD_RESULT valid that cycle
// MD_RESULT  out  XLEN  result; held until next accepted op completes
// BEHAVIOUR
// - Reset (RST_N=0, async): state=IDLE, counter=0, MD_BUSY=0, MD_VALID=0, MD_RESULT=0, internal regs 0.
// - States IDLE, CALC, DONE. MD_START is accepted only in IDLE or DONE; ignored in CALC (no queueing).
// - Accept, normal case: latch |A|, |B| and result-sign flags; counter=0; go to CALC.
// - CALC: one iteration per cycle. MUL* uses shift-add into a 2*XLEN product.
// - CALC: DIV*/REM* uses restoring divide (remainder XLEN+1 bits).
// - After iteration XLEN-1 (counter==31) go to DONE. DONE lasts one cycle; MD_VALID=1, then back to IDLE.
// - Latency: accept at edge T -> MD_VALID high in cycle T+33 (32 CALC cycles + DONE).
// - Signedness: MUL/MULH take A and B signed. MULHSU takes A signed, B unsigned. MULHU/DIVU/REMU are unsigned.
// - Negate the 64-bit product when sign(A)^sign(B) for the signed forms.
// - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
// - DIV quotient sign = sA^sB. REM remainder sign = sA (the dividend sign).
// - Special cases bypass CALC: accept -> DONE next cycle (MD_VALID at T+1).
// - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> A.
// - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
// - Zero operand on MUL* is NOT special: it takes the full 32 cycles.
// - MD_RESULT updates only on entry to DONE. MD_VALID is never high two cycles in a row unless back-to-back accepts occur.
// - Back-to-back: MD_START in DONE accepts the new op; the next MD_VALID follows the normal latency.
// - FLUSH has priority over MD_START and over the CALC/DONE progression.
// - On FLUSH the next state is IDLE, MD_BUSY=0 and MD_VALID=0 next cycle; MD_RESULT keeps its old value.
// - FLUSH in IDLE has no effect.
// - RST_N asserted mid-op: all outputs go to reset values immediately, with no pulse on release.
// - Operand inputs may change freely after the accept cycle; only latched copies are used.
// TESTING
// - MUL 7 x 0xFFFFFFFD (-3) -> MD_RESULT 0xFFFFFFEB; MD_VALID exactly at T+33; MD_BUSY high T+1..T+32.
// - MULH 0x80000000x0x80000000 -> 0x40000000.
// - MULHU 0xFFFFFFFFx0xFFFFFFFF -> 0xFFFFFFFE.
// - MULHSU 0xFFFFFFFFx0xFFFFFFFF -> 0xFFFFFFFF.
// - DIV 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD.
// - REM -7/2 -> 0xFFFFFFFF.
// - DIVU 100/7 -> 14.
// - REMU 100/7 -> 2.
// - DIV 5/0 -> 0xFFFFFFFF at T+1.
// - REMU 5/0 -> 5.
// - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
// - REM 0x80000000/0xFFFFFFFF -> 0.
// - MD_START pulsed at T+5 during CALC with different operands -> ignored; first result unchanged at T+33.
// - FLUSH at T+10 -> no MD_VALID; MD_BUSY=0 at T+11; MD_RESULT holds prior value.
// - RST_N low at T+12 -> MD_RESULT=0 and MD_BUSY=0 asynchronously.
// - Random: 10k ops with random MD_FUN/operands, random FLUSH -> every MD_RESULT matches the reference model; latency checked.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one result bit per cycle via shift-add
// multiply or restoring divide, with single-cycle bypass for divide special cases.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            MD_START,
  input  logic [2:0]      MD_FUN,
  input  logic [XLEN-1:0] ALU_srcA,
  input  logic [XLEN-1:0] ALU_srcB,
  input  logic            FLUSH,
  output logic            MD_BUSY,
  output logic            MD_VALID,
  output logic [XLEN-1:0] MD_RESULT,
  output logic [1:0]      md_state
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [2:0]      fun;
  logic            neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] rem, quo;

  // Handshake: MD_START is a one-cycle request taken only outside CALC and
  // only when FLUSH is low; MD_VALID is a one-cycle pulse in DONE, no back-pressure.
  logic            accept, special, last;
  logic            a_sgn, b_sgn, neg_in, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, special_res;
  logic [XLEN:0]   mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] prod_nxt, prod_fin;
  logic [XLEN-1:0] rem_nxt, quo_nxt, quo_fin, rem_fin, calc_res;

  always_comb begin
    accept   = MD_START && !FLUSH && (state != CALC);
    last     = (count == CW'(XLEN-1));
    a_sgn    = 1'b0;
    b_sgn    = 1'b0;
    case (MD_FUN)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        a_sgn = ALU_srcA[XLEN-1];
        b_sgn = ALU_srcB[XLEN-1];
      end
      3'd2:    a_sgn = ALU_srcA[XLEN-1];
      default: ;
    endcase
    a_mag    = a_sgn ? -ALU_srcA : ALU_srcA;
    b_mag    = b_sgn ? -ALU_srcB : ALU_srcB;
    // Remainder follows the dividend sign; everything else uses the xor.
    neg_in   = (MD_FUN[2] && MD_FUN[1]) ? a_sgn : (a_sgn ^ b_sgn);
    div_zero = MD_FUN[2] && (ALU_srcB == '0);
    div_ovf  = MD_FUN[2] && !MD_FUN[0] && (ALU_srcA == MIN_NEG) && (ALU_srcB == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = MD_FUN[1] ? ALU_srcA : '1;
    else          special_res = MD_FUN[1] ? '0 : MIN_NEG;

    // Shift-add: low half holds the remaining multiplier bits.
    mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a_abs} : '0);
    prod_nxt = {mul_sum, prod[XLEN-1:1]};
    // Restoring divide: rem < divisor, so a borrow shows in bit XLEN.
    rem_sh   = {rem, quo[XLEN-1]};
    diff     = rem_sh - {1'b0, b_abs};
    rem_nxt  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    quo_nxt  = {quo[XLEN-2:0], ~diff[XLEN]};

    prod_fin = neg ? -prod_nxt : prod_nxt;
    quo_fin  = neg ? -quo_nxt : quo_nxt;
    rem_fin  = neg ? -rem_nxt : rem_nxt;
    case (fun)
      3'd0:             calc_res = prod_fin[XLEN-1:0];
      3'd1, 3'd2, 3'd3: calc_res = prod_fin[2*XLEN-1:XLEN];
      3'd4, 3'd5:       calc_res = quo_fin;
      default:          calc_res = rem_fin;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CALC:    if (last) state_nxt = DONE;
      default: state_nxt = accept ? (special ? DONE : CALC) : IDLE;
    endcase
    if (FLUSH) state_nxt = IDLE;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count     <= '0;
      fun       <= '0;
      neg       <= 1'b0;
      a_abs     <= '0;
      b_abs     <= '0;
      prod      <= '0;
      rem       <= '0;
      quo       <= '0;
      MD_RESULT <= '0;
    end else if (accept) begin
      count <= '0;
      fun   <= MD_FUN;
      neg   <= neg_in;
      a_abs <= a_mag;
      b_abs <= b_mag;
      prod  <= {{XLEN{1'b0}}, b_mag};
      rem   <= '0;
      quo   <= a_mag;
      if (special) MD_RESULT <= special_res;
    end else if (state == CALC && !FLUSH) begin
      count <= count + 1'b1;
      prod  <= prod_nxt;
      rem   <= rem_nxt;
      quo   <= quo_nxt;
      if (last) MD_RESULT <= calc_res;
    end
  end

  assign MD_BUSY  = (state == CALC);
  assign MD_VALID = (state == DONE);
  assign md_state = state;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed table of RV32M vectors plus hand sequences for ignore-while-busy,
// flush, async reset mid-op and back-to-back issue; small random sweep at the end.
module tb_ex_muldiv_unit;

  logic        clk, rst_n, md_start, flush;
  logic [2:0]  md_fun;
  logic [31:0] src_a, src_b;
  logic        md_busy, md_valid;
  logic [31:0] md_result;
  logic [1:0]  md_state;

  int n_cmp  = 0;
  int n_fail = 0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .CLK(clk), .RST_N(rst_n), .MD_START(md_start), .MD_FUN(md_fun),
    .ALU_srcA(src_a), .ALU_srcB(src_b), .FLUSH(flush),
    .MD_BUSY(md_busy), .MD_VALID(md_valid), .MD_RESULT(md_result),
    .md_state(md_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fun;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        special;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic        ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Presents a request for one cycle; returns at the sample point of cycle T+1.
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_start = 1'b1;
    md_fun   = f;
    src_a    = a;
    src_b    = b;
    @(negedge clk);
    md_start = 1'b0;
    md_fun   = 3'($urandom_range(0, 7));
    src_a    = $urandom;
    src_b    = $urandom;
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int lat, output int busy_n);
    start_op(f, a, b);
    lat    = -1;
    busy_n = 0;
    r      = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (md_valid) begin
        lat = k;
        r   = md_result;
        break;
      end
      if (md_busy) busy_n++;
    end
  endtask

  initial begin
    logic [31:0] r;
    int          lat, busy_n, nval;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic        sp;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        1'b0};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         1'b0};
    vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         1'b1};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[12] = '{3'd0, 32'd0,          32'h1234_5678, 32'h0,         1'b0};
    vecs[13] = '{3'd1, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[14] = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[15] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         1'b0};
    vecs[16] = '{3'd2, 32'd2,          32'hFFFF_FFFF, 32'd1,         1'b0};

    rst_n = 1'b0; md_start = 1'b0; flush = 1'b0;
    md_fun = '0; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(md_busy), 32'd0);
    check("reset_valid", 32'(md_valid), 32'd0);
    check("reset_result", md_result, 32'h0);
    check("reset_state", 32'(md_state), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      do_op(vecs[i].fun, vecs[i].a, vecs[i].b, r, lat, busy_n);
      check($sformatf("vec%0d_result", i), r, vecs[i].exp);
      check_int($sformatf("vec%0d_latency", i), lat, vecs[i].special ? 1 : 33);
      check_int($sformatf("vec%0d_busy_cycles", i), busy_n, vecs[i].special ? 0 : 32);
      @(negedge clk);
      check($sformatf("vec%0d_valid_drop", i), 32'(md_valid), 32'd0);
    end

    // MD_START while busy must be dropped.
    start_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    lat = -1; r = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (md_valid && lat < 0) begin lat = k; r = md_result; end
      if (k == 4) begin md_start = 1'b1; md_fun = 3'd5; src_a = 32'd100; src_b = 32'd7; end
      if (k == 5) md_start = 1'b0;
    end
    check_int("ignore_latency", lat, 33);
    check("ignore_result", r, 32'hFFFF_FFEB);

    // FLUSH mid-CALC: no pulse, old result kept.
    start_op(3'd5, 32'd100, 32'd7);
    nval = 0;
    for (int k = 1; k <= 45; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 11) begin
        check("flush_busy", 32'(md_busy), 32'd0);
        check("flush_valid", 32'(md_valid), 32'd0);
        check("flush_result_hold", md_result, 32'hFFFF_FFEB);
        flush = 1'b0;
      end
      if (md_valid) nval++;
      if (k == 10) flush = 1'b1;
    end
    check_int("flush_no_valid", nval, 0);
    check("flush_result_after", md_result, 32'hFFFF_FFEB);

    // FLUSH in IDLE is harmless.
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check("idle_flush_state", 32'(md_state), 32'd0);
    check("idle_flush_result", md_result, 32'hFFFF_FFEB);
    do_op(3'd5, 32'd100, 32'd7, r, lat, busy_n);
    check("after_idle_flush_result", r, 32'd14);
    check_int("after_idle_flush_latency", lat, 33);

    // Async reset mid-op.
    start_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    for (int k = 2; k <= 12; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_result", md_result, 32'h0);
    check("async_rst_busy", 32'(md_busy), 32'd0);
    check("async_rst_valid", 32'(md_valid), 32'd0);
    check("async_rst_state", 32'(md_state), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    nval = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (md_valid) nval++;
    end
    check_int("rst_release_no_valid", nval, 0);

    // Back-to-back: new request during the DONE cycle of a bypassed divide.
    start_op(3'd4, 32'd5, 32'd0);
    check("b2b_first_valid", 32'(md_valid), 32'd1);
    check("b2b_first_result", md_result, 32'hFFFF_FFFF);
    md_start = 1'b1; md_fun = 3'd5; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    md_start = 1'b0; src_a = $urandom; src_b = $urandom;
    lat = -1; r = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (md_valid) begin lat = k; r = md_result; break; end
    end
    check_int("b2b_second_latency", lat, 33);
    check("b2b_second_result", r, 32'd14);

    // Random sweep against the reference model.
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      sp = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      do_op(f, a, b, r, lat, busy_n);
      check($sformatf("rnd%0d_f%0d_%h_%h", i, f, a, b), r, model(f, a, b));
      check_int($sformatf("rnd%0d_latency", i), lat, sp ? 1 : 33);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
